ol_walker: RTL and testbench
============================

OL_WALKER -- requirements
Module: ol_walker

Interface
REQ-001 Parameter LINK_LIMIT, default 1024; maximum link entries followed per list before abort.
REQ-002 Clocking: one clock; reset is synchronous and active-low.
REQ-003 clock  in  1  sole clock, all state on rising edge.
REQ-004 reset_n  in  1  synchronous active-low reset.
REQ-005 ol_start  in  1  one-cycle pulse; begin walking a list.
REQ-006 ol_base_addr  in  24  byte address of first object-list word, sampled on ol_start.
REQ-007 param_base  in  24  byte base of ISP/TSP parameter buffer, sampled on ol_start.
REQ-008 ol_vram_rd  out  1  read request, held until ol_vram_ack.
REQ-009 ol_vram_addr  out  24  word-aligned byte read address.
REQ-010 ol_vram_din  in  32  read data, valid with ol_vram_ack.
REQ-011 ol_vram_ack  in  1  read completion strobe.
REQ-012 prim_valid  out  1  primitive descriptor available to the ISP parser.
REQ-013 prim_ready  in  1  ISP parser accepts descriptor.
REQ-014 prim_type  out  2  0=strip, 1=tri array, 2=quad array.
REQ-015 prim_param_addr  out  24  param_base + offset*4.
REQ-016 prim_strip_mask  out  6  strip triangle enables T0..T5.
REQ-017 prim_count  out  4  array element count minus one, 0 for strips.
REQ-018 prim_skip  out  3  vertex skip field.
REQ-019 prim_shadow  out  1  two-volume/shadow flag.
REQ-020 ol_busy  out  1  high from accepted ol_start until done/error.
REQ-021 ol_done  out  1  one-cycle pulse on end-of-list link.
REQ-022 ol_error  out  1  one-cycle pulse on LINK_LIMIT overrun.

Function
REQ-023 States: IDLE, FETCH, DECODE, EMIT, DONE; ol_start in IDLE -> FETCH with ptr=ol_base_addr, link_cnt=0.
REQ-024 ol_start while ol_busy is ignored.
REQ-025 FETCH: assert ol_vram_rd, ol_vram_addr=ptr; on ol_vram_ack latch word, drop rd same edge, -> DECODE.
REQ-026 Decode: bit31=0 strip; [31:29]=100 tri array; 101 quad array; 111 link; 110 reserved.
REQ-027 Primitive fields: strip mask [30:25]; count [28:25]; shadow [24]; skip [23:21]; offset [20:0] words.
REQ-028 prim_param_addr = param_base + {offset,2'b00}, truncated to 24 bits (wraps).
REQ-029 Strip with mask 0 is discarded, no emission; ptr+=4, -> FETCH.
REQ-030 Valid primitive -> EMIT: prim_valid=1, all prim_* stable until prim_valid&&prim_ready.
REQ-031 On handshake: prim_valid=0 next cycle, ptr+=4 (24-bit wrap), -> FETCH; min one cycle between descriptors.
REQ-032 Link, bit28=1 (end of list): -> DONE, pulse ol_done, ol_busy=0, -> IDLE.
REQ-033 Link, bit28=0: ptr={word[23:2],2'b00}, link_cnt+=1; if link_cnt reaches LINK_LIMIT pulse ol_error, -> IDLE.
REQ-034 Reserved type 110 treated as end of list, sets ol_done.
REQ-035 prim_valid never asserted while ol_vram_rd asserted.

Reset
REQ-036 reset_n low at a clock edge: state=IDLE, ol_vram_rd=0, ol_vram_addr=0, prim_valid=0, all prim_* =0, ol_busy=0, ol_done=0, ol_error=0.
REQ-037 Reset mid-fetch or mid-emit abandons the list; a late ol_vram_ack in IDLE is ignored.

Structure
REQ-038 Shared package holds entry-type codes, field bit positions and prim_type encodings; the ISP parser imports the same.
REQ-039 Single module; one optional sub-module ol_entry_decode (combinational word -> fields).

Verification
REQ-040 List at 0x1000: strip 0x7E000010, link 0xF0000000; param_base 0x200000 -> one prim, type 0, mask 0x3F, addr 0x200040, then ol_done.
REQ-041 Tri array 0x86000020 with prim_ready low 5 cycles -> prim_valid held, count 3, addr=param_base+0x80 stable throughout.
REQ-042 Link 0xE0002000 at 0x1004 -> next fetch address 0x2000, walk continues.
REQ-043 Strip word 0x00000010 (mask 0) -> no prim_valid, next fetch at ptr+4.
REQ-044 Self-link loop with LINK_LIMIT=4 -> ol_error after 4th link, ol_busy low, no ol_done.
REQ-045 reset_n low while EMIT with ack pending -> all outputs zero next cycle; stray ack ignored.

Source files
------------

// File: rtl/ol_walker_pkg.sv
// Shared definitions for the object-list walker and the ISP parser: entry-type
// codes, bit positions of the fields inside a list word, and primitive type encodings.
package ol_walker_pkg;

  localparam int ADDR_W = 24;

  localparam int TYPE_MSB       = 31;
  localparam int TYPE_LSB       = 29;
  localparam int STRIP_FLAG_BIT = 31;
  localparam int LINK_END_BIT   = 28;
  localparam int MASK_MSB       = 30;
  localparam int MASK_LSB       = 25;
  localparam int COUNT_MSB      = 28;
  localparam int COUNT_LSB      = 25;
  localparam int SHADOW_BIT     = 24;
  localparam int SKIP_MSB       = 23;
  localparam int SKIP_LSB       = 21;
  localparam int OFFSET_MSB     = 20;
  localparam int LINK_ADDR_MSB  = 23;
  localparam int LINK_ADDR_LSB  = 2;

  localparam logic [2:0] CODE_TRI  = 3'b100;
  localparam logic [2:0] CODE_QUAD = 3'b101;
  localparam logic [2:0] CODE_RSVD = 3'b110;
  localparam logic [2:0] CODE_LINK = 3'b111;

  typedef enum logic [1:0] {
    PRIM_STRIP = 2'd0,
    PRIM_TRI   = 2'd1,
    PRIM_QUAD  = 2'd2
  } prim_type_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EMIT,
    ST_DONE
  } ol_state_e;

  // Word offset into the parameter buffer; the sum wraps at 24 bits.
  function automatic logic [ADDR_W-1:0] param_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [OFFSET_MSB:0] offset);
    return base + {1'b0, offset, 2'b00};
  endfunction

endpackage

// File: rtl/ol_entry_decode.sv
// Pure combinational split of one object-list word into its entry kind and
// primitive/link fields.
module ol_entry_decode
  import ol_walker_pkg::*;
(
  input  logic [31:0]         word,
  output logic                is_strip,
  output logic                is_tri,
  output logic                is_quad,
  output logic                is_link,
  output logic                is_end,
  output logic [5:0]          strip_mask,
  output logic [3:0]          count,
  output logic                shadow,
  output logic [2:0]          skip,
  output logic [OFFSET_MSB:0] offset,
  output logic [ADDR_W-1:0]   link_addr
);

  logic [2:0] code;

  assign code     = word[TYPE_MSB:TYPE_LSB];
  assign is_strip = ~word[STRIP_FLAG_BIT];
  assign is_tri   = (code == CODE_TRI);
  assign is_quad  = (code == CODE_QUAD);
  assign is_link  = (code == CODE_LINK) && !word[LINK_END_BIT];
  // The reserved code closes the list just like an end-of-list link.
  assign is_end   = ((code == CODE_LINK) && word[LINK_END_BIT]) || (code == CODE_RSVD);

  assign strip_mask = word[MASK_MSB:MASK_LSB];
  assign count      = word[COUNT_MSB:COUNT_LSB];
  assign shadow     = word[SHADOW_BIT];
  assign skip       = word[SKIP_MSB:SKIP_LSB];
  assign offset     = word[OFFSET_MSB:0];
  assign link_addr  = {word[LINK_ADDR_MSB:LINK_ADDR_LSB], 2'b00};

endmodule

// File: rtl/ol_walker.sv
// Object-list walker: fetches list words from VRAM, follows links and hands
// primitive descriptors to the ISP parser over a valid/ready handshake.
module ol_walker
  import ol_walker_pkg::*;
#(
  parameter int LINK_LIMIT = 1024
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ol_start,
  input  logic [23:0] ol_base_addr,
  input  logic [23:0] param_base,
  output logic        ol_vram_rd,
  output logic [23:0] ol_vram_addr,
  input  logic [31:0] ol_vram_din,
  input  logic        ol_vram_ack,
  output logic        prim_valid,
  input  logic        prim_ready,
  output logic [1:0]  prim_type,
  output logic [23:0] prim_param_addr,
  output logic [5:0]  prim_strip_mask,
  output logic [3:0]  prim_count,
  output logic [2:0]  prim_skip,
  output logic        prim_shadow,
  output logic        ol_busy,
  output logic        ol_done,
  output logic        ol_error
);

  localparam int CNT_W = $clog2(LINK_LIMIT + 1);

  ol_state_e          state, state_next;
  logic [ADDR_W-1:0]  ptr;
  logic [ADDR_W-1:0]  param_base_q;
  logic [31:0]        word_q;
  logic [CNT_W-1:0]   link_cnt;
  prim_type_e         prim_type_q;

  logic start_walk, latch_word, load_prim, ptr_step, ptr_link, error_next;

  logic                is_strip, is_tri, is_quad, is_link, is_end;
  logic [5:0]          d_mask;
  logic [3:0]          d_count;
  logic                d_shadow;
  logic [2:0]          d_skip;
  logic [OFFSET_MSB:0] d_offset;
  logic [ADDR_W-1:0]   d_link_addr;

  ol_entry_decode u_decode (
    .word       (word_q),
    .is_strip   (is_strip),
    .is_tri     (is_tri),
    .is_quad    (is_quad),
    .is_link    (is_link),
    .is_end     (is_end),
    .strip_mask (d_mask),
    .count      (d_count),
    .shadow     (d_shadow),
    .skip       (d_skip),
    .offset     (d_offset),
    .link_addr  (d_link_addr)
  );

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    ol_vram_rd = 1'b0;
    prim_valid = 1'b0;
    ol_busy    = 1'b0;
    ol_done    = 1'b0;
    start_walk = 1'b0;
    latch_word = 1'b0;
    load_prim  = 1'b0;
    ptr_step   = 1'b0;
    ptr_link   = 1'b0;
    error_next = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ol_start) begin
          start_walk = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        ol_busy    = 1'b1;
        ol_vram_rd = 1'b1;
        if (ol_vram_ack) begin
          latch_word = 1'b1;
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        ol_busy = 1'b1;
        if (is_strip && (d_mask == 6'd0)) begin
          ptr_step   = 1'b1;
          state_next = ST_FETCH;
        end else if (is_strip || is_tri || is_quad) begin
          load_prim  = 1'b1;
          state_next = ST_EMIT;
        end else if (is_link) begin
          ptr_link = 1'b1;
          // This link is the LINK_LIMIT-th one followed: give up on the list.
          if (link_cnt == CNT_W'(LINK_LIMIT - 1)) begin
            error_next = 1'b1;
            state_next = ST_IDLE;
          end else begin
            state_next = ST_FETCH;
          end
        end else if (is_end) begin
          state_next = ST_DONE;
        end
      end
      ST_EMIT: begin
        ol_busy    = 1'b1;
        prim_valid = 1'b1;
        if (prim_ready) begin
          ptr_step   = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_DONE: begin
        ol_done    = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      ptr             <= '0;
      param_base_q    <= '0;
      word_q          <= '0;
      link_cnt        <= '0;
      prim_type_q     <= PRIM_STRIP;
      prim_param_addr <= '0;
      prim_strip_mask <= '0;
      prim_count      <= '0;
      prim_skip       <= '0;
      prim_shadow     <= 1'b0;
      ol_error        <= 1'b0;
    end else begin
      state    <= state_next;
      ol_error <= error_next;
      if (start_walk) begin
        ptr          <= ol_base_addr & 24'hFF_FFFC;
        param_base_q <= param_base;
        link_cnt     <= '0;
      end
      if (latch_word) word_q <= ol_vram_din;
      if (ptr_step)   ptr    <= ptr + 24'd4;
      if (ptr_link) begin
        ptr      <= d_link_addr;
        link_cnt <= link_cnt + CNT_W'(1);
      end
      if (load_prim) begin
        prim_type_q     <= is_strip ? PRIM_STRIP : (is_tri ? PRIM_TRI : PRIM_QUAD);
        prim_param_addr <= param_addr(param_base_q, d_offset);
        prim_strip_mask <= is_strip ? d_mask : 6'd0;
        prim_count      <= is_strip ? 4'd0 : d_count;
        prim_skip       <= d_skip;
        prim_shadow     <= d_shadow;
      end
    end
  end

  assign ol_vram_addr = ptr;
  assign prim_type    = prim_type_q;

endmodule

// File: tb/tb_ol_walker.sv
// Directed bench for ol_walker: a VRAM responder and a prim monitor check fetch
// addresses and descriptors against queues filled by the stimulus.
module tb_ol_walker;

  logic        clock = 1'b0;
  logic        reset_n, ol_start;
  logic [23:0] ol_base_addr, param_base;
  logic        ol_vram_rd;
  logic [23:0] ol_vram_addr;
  logic [31:0] ol_vram_din;
  logic        ol_vram_ack;
  logic        prim_valid, prim_ready;
  logic [1:0]  prim_type;
  logic [23:0] prim_param_addr;
  logic [5:0]  prim_strip_mask;
  logic [3:0]  prim_count;
  logic [2:0]  prim_skip;
  logic        prim_shadow;
  logic        ol_busy, ol_done, ol_error;

  always #5 clock = ~clock;

  ol_walker #(.LINK_LIMIT(4)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .ol_start        (ol_start),
    .ol_base_addr    (ol_base_addr),
    .param_base      (param_base),
    .ol_vram_rd      (ol_vram_rd),
    .ol_vram_addr    (ol_vram_addr),
    .ol_vram_din     (ol_vram_din),
    .ol_vram_ack     (ol_vram_ack),
    .prim_valid      (prim_valid),
    .prim_ready      (prim_ready),
    .prim_type       (prim_type),
    .prim_param_addr (prim_param_addr),
    .prim_strip_mask (prim_strip_mask),
    .prim_count      (prim_count),
    .prim_skip       (prim_skip),
    .prim_shadow     (prim_shadow),
    .ol_busy         (ol_busy),
    .ol_done         (ol_done),
    .ol_error        (ol_error)
  );

  typedef struct packed {
    logic [1:0]  ptype;
    logic [23:0] addr;
    logic [5:0]  mask;
    logic [3:0]  cnt;
    logic [2:0]  skip;
    logic        shadow;
  } prim_t;

  logic [31:0] mem [logic [23:0]];
  logic [23:0] exp_fetch [$];
  prim_t       exp_prim [$];

  int n_checks    = 0;
  int n_pass      = 0;
  int ready_delay = 0;
  int done_cnt    = 0;
  int error_cnt   = 0;
  int valid_run   = 0;
  bit resp_en     = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic push_prim(input logic [1:0] t, input logic [23:0] a, input logic [5:0] m,
                           input logic [3:0] c, input logic [2:0] s, input logic sh);
    exp_prim.push_back({t, a, m, c, s, sh});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic start_walk(input logic [23:0] base, input logic [23:0] pb);
    tick(1);
    ol_start     = 1'b1;
    ol_base_addr = base;
    param_base   = pb;
    tick(1);
    ol_start = 1'b0;
  endtask

  task automatic wait_end(input string name, input int budget);
    int s;
    bit fin;
    s   = done_cnt + error_cnt;
    fin = 1'b0;
    for (int i = 0; i < budget && !fin; i++) begin
      @(posedge clock);
      if (done_cnt + error_cnt != s) fin = 1'b1;
    end
    check(name, fin, 1);
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ctrl"}, {ol_vram_rd, prim_valid, ol_busy, ol_done, ol_error}, 0);
    check({tag, "_addr"}, ol_vram_addr, 0);
    check({tag, "_prim"}, {prim_type, prim_param_addr, prim_strip_mask, prim_count,
                           prim_skip, prim_shadow}, 0);
  endtask

  // VRAM responder: ack each read two falling edges after rd rises.
  initial begin
    int lat;
    lat = 0;
    forever begin
      @(negedge clock);
      if (resp_en) begin
        ol_vram_ack = 1'b0;
        if (reset_n && ol_vram_rd) begin
          if (lat == 1) begin
            check("fetch_expected", exp_fetch.size() != 0, 1);
            if (exp_fetch.size() != 0) check("fetch_addr", ol_vram_addr, exp_fetch.pop_front());
            ol_vram_din = mem.exists(ol_vram_addr) ? mem[ol_vram_addr] : 32'hF000_0000;
            ol_vram_ack = 1'b1;
            lat = 0;
          end else begin
            lat++;
          end
        end else begin
          lat = 0;
        end
      end
    end
  end

  // Parser side: raise ready after ready_delay cycles of valid.
  initial begin
    int wait_cnt;
    wait_cnt   = 0;
    prim_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (!prim_valid) begin
        prim_ready = 1'b0;
        wait_cnt   = 0;
      end else if (wait_cnt >= ready_delay) begin
        prim_ready = 1'b1;
      end else begin
        prim_ready = 1'b0;
        wait_cnt++;
      end
    end
  end

  // Monitor: descriptors must match the queue head on every valid cycle.
  initial begin
    forever begin
      @(negedge clock);
      if (reset_n) begin
        if (ol_done)  done_cnt++;
        if (ol_error) error_cnt++;
        if (prim_valid) begin
          valid_run++;
          check("prim_expected", exp_prim.size() != 0, 1);
          check("valid_during_rd", ol_vram_rd, 0);
          if (exp_prim.size() != 0) begin
            check("prim_fields", {prim_type, prim_param_addr, prim_strip_mask, prim_count,
                                  prim_skip, prim_shadow}, exp_prim[0]);
            if (prim_ready) begin
              check("valid_hold_cycles", valid_run, ready_delay + 1);
              void'(exp_prim.pop_front());
              valid_run = 0;
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; ol_start = 1'b0; ol_base_addr = '0; param_base = '0;
    ol_vram_ack = 1'b0; ol_vram_din = '0;
    mem[24'h001000] = 32'h7E00_0010;
    mem[24'h001004] = 32'hF000_0000;
    mem[24'h003000] = 32'h0000_0010;
    mem[24'h003004] = 32'h8600_0020;
    mem[24'h003008] = 32'hE000_2000;
    mem[24'h002000] = 32'hAFA0_0005;
    mem[24'h002004] = 32'hF000_0000;
    mem[24'h004000] = 32'h037F_FFFF;
    mem[24'h004004] = 32'hC000_0000;
    mem[24'h005000] = 32'hE000_5000;
    mem[24'h006000] = 32'h8600_0020;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check_zero_outputs("reset");
    tick(1);
    reset_n = 1'b1;

    // Strip with full mask then end-of-list link.
    exp_fetch.push_back(24'h001000); exp_fetch.push_back(24'h001004);
    push_prim(2'd0, 24'h200040, 6'h3F, 4'd0, 3'd0, 1'b0);
    start_walk(24'h001000, 24'h200000);
    wait_end("t1_end", 100);
    check("t1_done", done_cnt, 1);
    check("t1_error", error_cnt, 0);
    check("t1_busy", ol_busy, 0);
    check("t1_queues", exp_prim.size() + exp_fetch.size(), 0);

    // Empty strip, stalled tri array, link to 0x2000, quad array, end.
    ready_delay = 5;
    exp_fetch.push_back(24'h003000); exp_fetch.push_back(24'h003004);
    exp_fetch.push_back(24'h003008); exp_fetch.push_back(24'h002000);
    exp_fetch.push_back(24'h002004);
    push_prim(2'd1, 24'h200080, 6'h00, 4'd3, 3'd0, 1'b0);
    push_prim(2'd2, 24'h200014, 6'h00, 4'd7, 3'd5, 1'b1);
    start_walk(24'h003000, 24'h200000);
    wait_end("t2_end", 300);
    check("t2_done", done_cnt, 2);
    check("t2_queues", exp_prim.size() + exp_fetch.size(), 0);

    // Parameter address wrap, reserved code ends list, start while busy ignored.
    ready_delay = 0;
    exp_fetch.push_back(24'h004000); exp_fetch.push_back(24'h004004);
    push_prim(2'd0, 24'h7FFFEC, 6'h01, 4'd0, 3'd3, 1'b1);
    start_walk(24'h004000, 24'hFFFFF0);
    tick(1);
    check("t3_busy", ol_busy, 1);
    ol_start = 1'b1; ol_base_addr = 24'h007000; param_base = 24'h000000;
    tick(1);
    ol_start = 1'b0;
    wait_end("t3_end", 200);
    check("t3_done", done_cnt, 3);
    check("t3_error", error_cnt, 0);
    check("t3_queues", exp_prim.size() + exp_fetch.size(), 0);

    // Self-link loop aborts after the fourth link.
    for (int i = 0; i < 4; i++) exp_fetch.push_back(24'h005000);
    start_walk(24'h005000, 24'h000000);
    wait_end("t4_end", 200);
    check("t4_error", error_cnt, 1);
    check("t4_no_done", done_cnt, 3);
    check("t4_busy", ol_busy, 0);
    check("t4_queues", exp_fetch.size(), 0);

    // Reset while emitting, with a stray ack arriving afterwards.
    ready_delay = 100;
    exp_fetch.push_back(24'h006000);
    push_prim(2'd1, 24'h100080, 6'h00, 4'd3, 3'd0, 1'b0);
    start_walk(24'h006000, 24'h100000);
    for (int i = 0; i < 50 && !prim_valid; i++) tick(1);
    check("t5_valid_seen", prim_valid, 1);
    tick(2);
    resp_en = 1'b0;
    reset_n = 1'b0;
    ol_vram_ack = 1'b1;
    ol_vram_din = 32'h8600_0020;
    @(posedge clock);
    @(negedge clock);
    check_zero_outputs("t5_reset");
    tick(1);
    reset_n = 1'b1;
    tick(1);
    ol_vram_ack = 1'b0;
    tick(2);
    check("t5_idle", {ol_vram_rd, prim_valid, ol_busy}, 0);
    check("t5_no_done", done_cnt, 3);
    exp_prim.delete();
    valid_run   = 0;
    ready_delay = 0;
    resp_en     = 1'b1;

    // Walk again after the abandoned list.
    exp_fetch.push_back(24'h001000); exp_fetch.push_back(24'h001004);
    push_prim(2'd0, 24'h200040, 6'h3F, 4'd0, 3'd0, 1'b0);
    start_walk(24'h001000, 24'h200000);
    wait_end("t6_end", 100);
    check("t6_done", done_cnt, 4);
    check("t6_error", error_cnt, 1);
    check("t6_queues", exp_prim.size() + exp_fetch.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
